// File: rtl/readback_pkg.sv
// readback_pkg: register map, bit positions and per-queue status record shared by
// the host read path and its output queues.
package readback_pkg;
    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_POP1   = 4'd1;
    localparam logic [3:0] ADDR_POP2   = 4'd2;
    localparam logic [3:0] ADDR_POP3   = 4'd3;
    localparam logic [3:0] ADDR_COUNT1 = 4'd4;
    localparam logic [3:0] ADDR_COUNT2 = 4'd5;
    localparam logic [3:0] ADDR_COUNT3 = 4'd6;
    localparam logic [3:0] ADDR_CTRL   = 4'd7;
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 4;
    localparam int ST_OVF       = 8;
    localparam int ST_UDF       = 12;
    localparam int CTRL_OVF_CLR = 0;
    localparam int CTRL_UDF_CLR = 4;
    localparam int CTRL_IRQ_EN  = 8;
    typedef struct packed {
        logic empty;
        logic full;
        logic ovf;
        logic udf;
    } queue_status_t;
endpackage

// File: rtl/port_readback_out_fifo.sv
// out_fifo: synchronous first-word-fall-through queue; push is refused when full and
// pop is refused when empty, so the occupancy count can never wrap.
module out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNTW-1:0]  count,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNTW-1:0] count_q, count_d;
    logic do_push, do_pop;
    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end
    assign dout  = mem[rd_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNTW'(DEPTH));
endmodule

// File: rtl/port_readback.sv
// port_readback: Avalon-MM responder that queues the three switch output ports and
// lets the host pop them, read status/counts and clear sticky error flags.
module port_readback
    import readback_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [3:0]       address,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] out_data1,
    input  logic [WIDTH-1:0] out_data2,
    input  logic [WIDTH-1:0] out_data3,
    input  logic             out_valid1,
    input  logic             out_valid2,
    input  logic             out_valid3,
    output logic             out_ready1,
    output logic             out_ready2,
    output logic             out_ready3,
    output logic             irq
);
    localparam int CNTW = $clog2(DEPTH) + 1;
    logic rd, wr, ctrl_wr;
    logic [WIDTH-1:0] din [3];
    logic [WIDTH-1:0] dout [3];
    logic [CNTW-1:0] count [3];
    logic [2:0] vld, push, pop, empty, full;
    queue_status_t qs [3];
    logic [2:0] ovf_q, ovf_d, udf_q, udf_d;
    logic irq_en_q, irq_en_d, irq_q, irq_d;
    logic [WIDTH-1:0] readdata_q, readdata_d, status_word, rdata;
    logic unused_wdata;
    assign rd      = chipselect & read & ~write;
    assign wr      = chipselect & write;
    assign ctrl_wr = wr & (address == ADDR_CTRL);
    assign din     = '{out_data1, out_data2, out_data3};
    assign vld     = {out_valid3, out_valid2, out_valid1};
    assign unused_wdata = ^{writedata[WIDTH-1:9], writedata[7], writedata[3]};
    for (genvar i = 0; i < 3; i++) begin : g_q
        assign push[i] = vld[i] & ~full[i];
        assign pop[i]  = rd & (address == ADDR_POP1 + 4'(i));
        assign qs[i]   = '{empty: empty[i], full: full[i], ovf: ovf_q[i], udf: udf_q[i]};
        out_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNTW(CNTW)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (din[i]),
            .dout  (dout[i]),
            .count (count[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end
    always_comb begin
        status_word = '0;
        for (int n = 0; n < 3; n++) begin
            status_word[ST_EMPTY+n] = qs[n].empty;
            status_word[ST_FULL+n]  = qs[n].full;
            status_word[ST_OVF+n]   = qs[n].ovf;
            status_word[ST_UDF+n]   = qs[n].udf;
        end
        rdata = (address == ADDR_STATUS) ? status_word :
                (address == ADDR_POP1)   ? (empty[0] ? '0 : dout[0]) :
                (address == ADDR_POP2)   ? (empty[1] ? '0 : dout[1]) :
                (address == ADDR_POP3)   ? (empty[2] ? '0 : dout[2]) :
                (address == ADDR_COUNT1) ? WIDTH'(count[0]) :
                (address == ADDR_COUNT2) ? WIDTH'(count[1]) :
                (address == ADDR_COUNT3) ? WIDTH'(count[2]) :
                (address == ADDR_CTRL)   ? (WIDTH'(irq_en_q) << CTRL_IRQ_EN) : '0;
        // A new event in the same cycle as its clear keeps the flag set.
        ovf_d      = (vld & full) | (ovf_q & ~({3{ctrl_wr}} & writedata[CTRL_OVF_CLR +: 3]));
        udf_d      = (pop & empty) | (udf_q & ~({3{ctrl_wr}} & writedata[CTRL_UDF_CLR +: 3]));
        irq_en_d   = ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en_q;
        irq_d      = irq_en_q & ~&empty;
        readdata_d = rd ? rdata : readdata_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q      <= '0;
            udf_q      <= '0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end
    assign readdata   = readdata_q;
    assign irq        = irq_q;
    assign out_ready1 = ~full[0];
    assign out_ready2 = ~full[1];
    assign out_ready3 = ~full[2];
endmodule
